// File: rtl/ram_buff_sched.sv
// ram_buffer load-job sequencer and RAM read-port arbiter.
// Buffer reads take strict priority; a tag pipe steers returning data by source.
`timescale 1ns/1ps
module ram_buff_sched #(
  parameter int CMD_DEPTH = 2,
  parameter int RD_LAT    = 1,
  parameter int RAM_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  input  logic [3:0]           cmd_start_byte,
  input  logic [3:0]           cmd_end_byte,
  input  logic [3:0]           cmd_ent_num,
  input  logic [7:0]           cmd_start_addr,
  input  logic [4:0]           cmd_ent_rng,
  output logic                 ctrl_ram_buff_vld,
  output logic [3:0]           ctrl_ram_buff_start_byte,
  output logic [3:0]           ctrl_ram_buff_end_byte,
  output logic [3:0]           ctrl_ram_buff_ent_num,
  output logic [7:0]           ctrl_ram_buff_start_addr,
  output logic [4:0]           ctrl_ram_buff_ent_rng,
  input  logic                 buff_read_vld,
  input  logic [7:0]           buff_read_addr,
  input  logic                 buff_send_done,
  input  logic                 axi_read_vld,
  input  logic [7:0]           axi_read_addr,
  output logic                 axi_read_gnt,
  output logic                 ram_rd_en,
  output logic [7:0]           ram_rd_addr,
  input  logic                 ram_rdata_vld,
  input  logic [RAM_WIDTH-1:0] ram_rdata,
  output logic                 ram_buff_alloc_vld,
  output logic [7:0]           ram_buff_alloc_addr,
  output logic [RAM_WIDTH-1:0] ram_buff_alloc_data,
  output logic                 axi_rdata_vld,
  output logic [RAM_WIDTH-1:0] axi_rdata,
  output logic                 sched_busy,
  output logic                 sched_done
);

  localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = $clog2(CMD_DEPTH) + 1;

  typedef struct packed {
    logic [3:0] sb;
    logic [3:0] eb;
    logic [3:0] en;
    logic [7:0] sa;
    logic [4:0] rng;
  } cmd_t;

  typedef struct packed {
    logic       v;
    logic       axi;
    logic [7:0] addr;
  } tag_t;

  typedef enum logic [1:0] {
    IDLE, LAUNCH, FILL, DRAIN
  } st_t;

  st_t            state_q;
  cmd_t           mem_q [CMD_DEPTH];
  cmd_t           head;
  cmd_t           cmd_in;
  logic [AW-1:0]  wp_q, rp_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rdy_q;
  logic           push, pop;
  logic [4:0]     alloc_cnt_q;
  logic [3:0]     en_q;
  cmd_t           ctrl_q;
  logic           ctrl_vld_q;
  tag_t           tag_q [RD_LAT];
  tag_t           tag_head;
  logic           hit;

  assign cmd_in = '{sb: cmd_start_byte, eb: cmd_end_byte,
                    en: cmd_ent_num, sa: cmd_start_addr,
                    rng: cmd_ent_rng};
  assign head   = mem_q[rp_q];
  assign push   = cmd_vld & rdy_q;
  assign pop    = (state_q == IDLE) & (cnt_q != '0);
  assign cnt_d  = cnt_q + CW'(push) - CW'(pop);
  assign cmd_rdy = rdy_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != CW'(CMD_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ctrl_vld_q  <= 1'b0;
      ctrl_q      <= '0;
      en_q        <= '0;
      alloc_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q    <= LAUNCH;
            ctrl_vld_q <= 1'b1;
            ctrl_q     <= head;
            en_q       <= head.en;
          end
        end
        LAUNCH: begin
          ctrl_vld_q  <= 1'b0;
          alloc_cnt_q <= '0;
          state_q     <= FILL;
        end
        FILL: begin
          if (ram_buff_alloc_vld) begin
            if (alloc_cnt_q == {1'b0, en_q}) state_q <= DRAIN;
            else alloc_cnt_q <= alloc_cnt_q + 5'd1;
          end
        end
        DRAIN: begin
          if (buff_send_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctrl_ram_buff_vld        = ctrl_vld_q;
  assign ctrl_ram_buff_start_byte = ctrl_q.sb;
  assign ctrl_ram_buff_end_byte   = ctrl_q.eb;
  assign ctrl_ram_buff_ent_num    = ctrl_q.en;
  assign ctrl_ram_buff_start_addr = ctrl_q.sa;
  assign ctrl_ram_buff_ent_rng    = ctrl_q.rng;

  assign sched_busy = (state_q != IDLE);
  assign sched_done = (state_q == DRAIN) & buff_send_done & ~rst;

  assign axi_read_gnt = axi_read_vld & ~buff_read_vld & ~rst;
  assign ram_rd_en    = (buff_read_vld & ~rst) | axi_read_gnt;

  always_comb begin
    ram_rd_addr = '0;
    if (!rst) begin
      if (buff_read_vld)     ram_rd_addr = buff_read_addr;
      else if (axi_read_gnt) ram_rd_addr = axi_read_addr;
    end
  end

  // tag[RD_LAT-1] lines up with the data returning for a read RD_LAT cycles ago
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{v: ram_rd_en, axi: axi_read_gnt, addr: ram_rd_addr};
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_head = tag_q[RD_LAT-1];
  assign hit      = ram_rdata_vld & tag_head.v & ~rst;

  assign ram_buff_alloc_vld  = hit & ~tag_head.axi;
  assign ram_buff_alloc_addr = ram_buff_alloc_vld ? tag_head.addr : '0;
  assign ram_buff_alloc_data = ram_buff_alloc_vld ? ram_rdata : '0;
  assign axi_rdata_vld       = hit & tag_head.axi;
  assign axi_rdata           = axi_rdata_vld ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_buff_sched.sv
// Scoreboard bench for ram_buff_sched.
// RAM model with RD_LAT=3; monitor pops expected data per output.
`timescale 1ns/1ps
module tb_ram_buff_sched;
  localparam int RL = 3;
  localparam int W  = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         cmd_vld, cmd_rdy;
  logic [3:0]   cmd_start_byte, cmd_end_byte, cmd_ent_num;
  logic [7:0]   cmd_start_addr;
  logic [4:0]   cmd_ent_rng;
  logic         c_vld;
  logic [3:0]   c_sb, c_eb, c_en;
  logic [7:0]   c_sa;
  logic [4:0]   c_rng;
  logic         buff_read_vld, buff_send_done;
  logic [7:0]   buff_read_addr;
  logic         axi_read_vld, axi_read_gnt;
  logic [7:0]   axi_read_addr;
  logic         ram_rd_en;
  logic [7:0]   ram_rd_addr;
  logic         ram_rdata_vld;
  logic [W-1:0] ram_rdata;
  logic         al_vld;
  logic [7:0]   al_addr;
  logic [W-1:0] al_data;
  logic         axi_rdata_vld;
  logic [W-1:0] axi_rdata;
  logic         sched_busy, sched_done;

  ram_buff_sched #(.CMD_DEPTH(2), .RD_LAT(RL), .RAM_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_start_byte(cmd_start_byte), .cmd_end_byte(cmd_end_byte),
    .cmd_ent_num(cmd_ent_num), .cmd_start_addr(cmd_start_addr),
    .cmd_ent_rng(cmd_ent_rng),
    .ctrl_ram_buff_vld(c_vld), .ctrl_ram_buff_start_byte(c_sb),
    .ctrl_ram_buff_end_byte(c_eb), .ctrl_ram_buff_ent_num(c_en),
    .ctrl_ram_buff_start_addr(c_sa), .ctrl_ram_buff_ent_rng(c_rng),
    .buff_read_vld(buff_read_vld), .buff_read_addr(buff_read_addr),
    .buff_send_done(buff_send_done),
    .axi_read_vld(axi_read_vld), .axi_read_addr(axi_read_addr),
    .axi_read_gnt(axi_read_gnt),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rdata_vld(ram_rdata_vld), .ram_rdata(ram_rdata),
    .ram_buff_alloc_vld(al_vld), .ram_buff_alloc_addr(al_addr),
    .ram_buff_alloc_data(al_data),
    .axi_rdata_vld(axi_rdata_vld), .axi_rdata(axi_rdata),
    .sched_busy(sched_busy), .sched_done(sched_done)
  );

  function automatic logic [W-1:0] f(input logic [7:0] a);
    return {8{a, ~a}};
  endfunction

  // RAM macro: fixed latency, no reset, so stale data survives a DUT reset
  logic [RL-1:0] pv = '0;
  logic [7:0]    pa [RL];
  initial for (int i = 0; i < RL; i++) pa[i] = '0;
  always @(posedge clk) begin
    pv    <= {pv[RL-2:0], ram_rd_en};
    pa[0] <= ram_rd_addr;
    for (int i = 1; i < RL; i++) pa[i] <= pa[i-1];
  end
  assign ram_rdata_vld = pv[RL-1];
  assign ram_rdata     = f(pa[RL-1]);

  int total = 0;
  int bad   = 0;
  logic [7:0]   qa [$];
  logic [W-1:0] qd [$];
  logic [W-1:0] qx [$];
  logic [24:0]  qc [$];
  logic         done_exp = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s act=unexpected exp=none", nm);
  endtask

  always @(negedge clk) begin
    if (al_vld) begin
      if (qa.size() == 0) miss("alloc");
      else begin
        chk("alloc_addr", W'(al_addr), W'(qa.pop_front()));
        chk("alloc_data", al_data, qd.pop_front());
      end
    end
    if (axi_rdata_vld) begin
      if (qx.size() == 0) miss("axi_rdata");
      else chk("axi_rdata", axi_rdata, qx.pop_front());
    end
    if (c_vld) begin
      if (qc.size() == 0) miss("ctrl");
      else chk("ctrl_fields", W'({c_sb, c_eb, c_en, c_sa, c_rng}),
               W'(qc.pop_front()));
    end
    if (sched_done || done_exp)
      chk("sched_done", W'(sched_done), W'(done_exp));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] sb, input logic [3:0] eb,
                          input logic [3:0] en, input logic [7:0] sa,
                          input logic [4:0] rng);
    int n = 0;
    while (!cmd_rdy && n < 40) begin
      cyc();
      n++;
    end
    if (!cmd_rdy) miss("cmd_rdy_timeout");
    cmd_vld        = 1'b1;
    cmd_start_byte = sb;
    cmd_end_byte   = eb;
    cmd_ent_num    = en;
    cmd_start_addr = sa;
    cmd_ent_rng    = rng;
    qc.push_back({sb, eb, en, sa, rng});
    cyc();
    cmd_vld = 1'b0;
  endtask

  task automatic wait_launch();
    int n = 0;
    while (!c_vld && n < 30) begin
      cyc();
      n++;
    end
    if (!c_vld) miss("launch_timeout");
    cyc();
  endtask

  task automatic fill_drain(input logic [3:0] en, input logic [7:0] sa);
    for (int i = 0; i <= int'(en); i++) begin
      buff_read_vld  = 1'b1;
      buff_read_addr = sa + 8'(i);
      qa.push_back(sa + 8'(i));
      qd.push_back(f(sa + 8'(i)));
      cyc();
    end
    buff_read_vld = 1'b0;
    repeat (RL + 1) cyc();
    chk("busy_drain", W'(sched_busy), W'(1));
    buff_send_done = 1'b1;
    done_exp       = 1'b1;
    cyc();
    buff_send_done = 1'b0;
    done_exp       = 1'b0;
    chk("busy_after_done", W'(sched_busy), W'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_vld = 1'b0; cmd_start_byte = '0; cmd_end_byte = '0;
    cmd_ent_num = '0; cmd_start_addr = '0; cmd_ent_rng = '0;
    buff_read_vld = 1'b0; buff_read_addr = '0; buff_send_done = 1'b0;
    axi_read_vld = 1'b0; axi_read_addr = '0;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("rst_ctrl_vld", W'(c_vld), W'(0));
    chk("rst_rd_en", W'(ram_rd_en), W'(0));
    chk("rst_gnt", W'(axi_read_gnt), W'(0));
    chk("rst_busy", W'(sched_busy), W'(0));
    chk("rst_alloc", W'(al_vld), W'(0));
    chk("rst_axi_vld", W'(axi_rdata_vld), W'(0));
    cyc();
    chk("rst_cmd_rdy", W'(cmd_rdy), W'(1));

    // single job
    send_cmd(4'd2, 4'd13, 4'd3, 8'h10, 5'd3);
    wait_launch();
    chk("busy_fill", W'(sched_busy), W'(1));
    fill_drain(4'd3, 8'h10);
    cyc();

    // three queued jobs, depth 2
    send_cmd(4'd0, 4'd15, 4'd1, 8'h50, 5'd2);
    wait_launch();
    send_cmd(4'd1, 4'd7, 4'd0, 8'h60, 5'h1f);
    send_cmd(4'd3, 4'd9, 4'd2, 8'h70, 5'h1d);
    chk("cmd_rdy_full", W'(cmd_rdy), W'(0));
    fill_drain(4'd1, 8'h50);
    wait_launch();
    chk("cmd_rdy_after_pop", W'(cmd_rdy), W'(1));
    fill_drain(4'd0, 8'h60);
    wait_launch();
    fill_drain(4'd2, 8'h70);
    cyc();

    // simultaneous requests: buffer wins
    buff_read_vld = 1'b1; buff_read_addr = 8'h40;
    axi_read_vld  = 1'b1; axi_read_addr  = 8'h80;
    #1;
    chk("arb_gnt_lose", W'(axi_read_gnt), W'(0));
    chk("arb_addr_buff", W'(ram_rd_addr), W'(8'h40));
    qa.push_back(8'h40); qd.push_back(f(8'h40));
    cyc();
    buff_read_vld = 1'b0;
    #1;
    chk("arb_gnt_win", W'(axi_read_gnt), W'(1));
    chk("arb_addr_axi", W'(ram_rd_addr), W'(8'h80));
    qx.push_back(f(8'h80));
    cyc();
    axi_read_vld = 1'b0;
    repeat (RL + 2) cyc();

    // alternating sources every cycle
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        buff_read_vld = 1'b1; axi_read_vld = 1'b0;
        buff_read_addr = 8'h20 + 8'(i);
        qa.push_back(8'h20 + 8'(i)); qd.push_back(f(8'h20 + 8'(i)));
      end else begin
        buff_read_vld = 1'b0; axi_read_vld = 1'b1;
        axi_read_addr = 8'h90 + 8'(i);
        qx.push_back(f(8'h90 + 8'(i)));
      end
      cyc();
    end
    buff_read_vld = 1'b0; axi_read_vld = 1'b0;
    repeat (RL + 2) cyc();

    // reset mid-fill with reads in flight and a queued command
    send_cmd(4'd0, 4'd0, 4'd7, 8'h30, 5'd7);
    wait_launch();
    send_cmd(4'd5, 4'd6, 4'd1, 8'hA0, 5'd1);
    buff_read_vld = 1'b1; buff_read_addr = 8'h30;
    cyc();
    buff_read_addr = 8'h31;
    cyc();
    buff_read_vld = 1'b0;
    rst = 1'b1;
    void'(qc.pop_back());
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", W'(sched_busy), W'(0));
    chk("rst_mid_ctrl", W'(c_vld), W'(0));
    cyc();
    chk("rst_mid_rdy", W'(cmd_rdy), W'(1));
    repeat (6) cyc();
    chk("rst_mid_flushed", W'(sched_busy), W'(0));

    repeat (3) cyc();
    chk("left_alloc", W'(qa.size()), W'(0));
    chk("left_axi", W'(qx.size()), W'(0));
    chk("left_ctrl", W'(qc.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
